vsfx_issue_arb: RTL and testbench

//  Shares a single vsfx_top vector fixed-point datapath between two requesters.
//  Per cycle, a round-robin arbiter grants at most one request and registers its

---
 rtl/vsfx_issue_arb.sv | 129 ++++++++++++
 tb/tb_vsfx_issue_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsfx_issue_arb.sv
// vsfx_issue_arb: round-robin issue of two requesters onto one vsfx datapath,
// with an in-order tag pipe and a credit-protected response FIFO.
module vsfx_issue_arb #(
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_vra,
  input  logic [127:0] req0_vrb,
  input  logic [7:0]   req0_ins,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_vra,
  input  logic [127:0] req1_vrb,
  input  logic [7:0]   req1_ins,
  output logic         dp_en,
  output logic [127:0] dp_vra,
  output logic [127:0] dp_vrb,
  output logic [7:0]   dp_ins,
  input  logic         dp_vrt_en,
  input  logic [127:0] dp_vrt,
  input  logic         dp_sat,
  input  logic [3:0]   dp_cr6,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_vrt,
  output logic         rsp_sat,
  output logic [3:0]   rsp_cr6,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic         id;
    logic [127:0] vrt;
    logic         sat;
    logic [3:0]   cr6;
  } rsp_t;

  logic [CW-1:0] cnt;
  logic [CW-1:0] fcnt;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          rr_ptr;
  logic [LAT:0]  tv;
  logic [LAT:0]  tid;
  rsp_t          mem [FIFO_DEPTH];
  rsp_t          head;

  logic credit;
  logic g0;
  logic g1;
  logic accept;
  logic pop;
  logic push;
  logic tag_vld;

  assign rsp_valid = (fcnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  // A pop in the same cycle frees the slot a full credit count is waiting on
  assign credit    = rst & ((cnt != FULL) | pop);
  assign g0        = credit & req0_valid & (~req1_valid | ~rr_ptr);
  assign g1        = credit & req1_valid & (~req0_valid | rr_ptr);
  assign accept    = g0 | g1;
  assign req0_ready = g0;
  assign req1_ready = g1;

  assign tag_vld = tv[LAT];
  assign push    = dp_vrt_en & tag_vld;
  assign busy    = (cnt != '0);

  assign head    = mem[rp];
  assign rsp_id  = rsp_valid & head.id;
  assign rsp_vrt = rsp_valid ? head.vrt : '0;
  assign rsp_sat = rsp_valid & head.sat;
  assign rsp_cr6 = rsp_valid ? head.cr6 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      rr_ptr <= 1'b0;
      dp_en  <= 1'b0;
      dp_vra <= '0;
      dp_vrb <= '0;
      dp_ins <= '0;
      tv     <= '0;
      tid    <= '0;
      err    <= 1'b0;
      fcnt   <= '0;
      wp     <= '0;
      rp     <= '0;
    end else begin
      cnt   <= cnt + CW'(accept) - CW'(pop);
      dp_en <= accept;
      tv    <= {tv[LAT-1:0], accept};
      tid   <= {tid[LAT-1:0], g1};
      if (accept) begin
        rr_ptr <= ~g1;
        dp_vra <= g1 ? req1_vra : req0_vra;
        dp_vrb <= g1 ? req1_vrb : req0_vrb;
        dp_ins <= g1 ? req1_ins : req0_ins;
      end
      if (dp_vrt_en && !tag_vld)
        err <= 1'b1;
      fcnt <= fcnt + CW'(push) - CW'(pop);
      if (push)
        wp <= wp + PW'(1);
      if (pop)
        rp <= rp + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= '{id: tid[LAT], vrt: dp_vrt, sat: dp_sat, cr6: dp_cr6};
  end

  a_no_ovf: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && fcnt == FULL));

endmodule

// File: tb/tb_vsfx_issue_arb.sv
// tb_vsfx_issue_arb: directed bench for vsfx_issue_arb with a LAT=1
// byte-add datapath stub and an in-order response scoreboard.
module tb_vsfx_issue_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid, req0_ready;
  logic [127:0] req0_vra, req0_vrb;
  logic [7:0]   req0_ins;
  logic         req1_valid, req1_ready;
  logic [127:0] req1_vra, req1_vrb;
  logic [7:0]   req1_ins;
  logic         dp_en;
  logic [127:0] dp_vra, dp_vrb;
  logic [7:0]   dp_ins;
  logic         dp_vrt_en;
  logic [127:0] dp_vrt;
  logic         dp_sat;
  logic [3:0]   dp_cr6;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [127:0] rsp_vrt;
  logic         rsp_sat;
  logic [3:0]   rsp_cr6;
  logic         busy, err;

  logic         m_en;
  logic [127:0] m_vrt;
  logic         inj;

  int n_run  = 0;
  int n_fail = 0;

  logic         q_id  [$];
  logic [127:0] q_vrt [$];
  logic [7:0]   q_ins [$];

  always #5 clk = ~clk;

  vsfx_issue_arb #(.LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_vra(req0_vra), .req0_vrb(req0_vrb), .req0_ins(req0_ins),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_vra(req1_vra), .req1_vrb(req1_vrb), .req1_ins(req1_ins),
    .dp_en(dp_en), .dp_vra(dp_vra), .dp_vrb(dp_vrb), .dp_ins(dp_ins),
    .dp_vrt_en(dp_vrt_en), .dp_vrt(dp_vrt),
    .dp_sat(dp_sat), .dp_cr6(dp_cr6),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_vrt(rsp_vrt), .rsp_sat(rsp_sat), .rsp_cr6(rsp_cr6),
    .busy(busy), .err(err)
  );

  function automatic logic [127:0] badd(input logic [127:0] a, b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
    return r;
  endfunction

  // Datapath stub: byte-wise add, one cycle latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en  <= 1'b0;
      m_vrt <= '0;
    end else begin
      m_en  <= dp_en;
      m_vrt <= badd(dp_vra, dp_vrb);
    end
  end

  assign dp_vrt_en = m_en | inj;
  assign dp_vrt    = m_vrt;
  assign dp_sat    = m_vrt[0];
  assign dp_cr6    = m_vrt[11:8];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [127:0] v;
    #1;
    chk("dual_grant", req0_ready & req1_ready, 0);
    if (req0_valid && req0_ready) begin
      q_id.push_back(1'b0);
      q_vrt.push_back(badd(req0_vra, req0_vrb));
      q_ins.push_back(req0_ins);
    end else if (req1_valid && req1_ready) begin
      q_id.push_back(1'b1);
      q_vrt.push_back(badd(req1_vra, req1_vrb));
      q_ins.push_back(req1_ins);
    end
    if (rsp_valid && rsp_ready) begin
      if (q_id.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        v = q_vrt.pop_front();
        chk("rsp_id", rsp_id, q_id.pop_front());
        chk("rsp_vrt", rsp_vrt, v);
        chk("rsp_flags", {rsp_sat, rsp_cr6}, {v[0], v[11:8]});
      end
    end
    @(posedge clk);
    #1;
    if (dp_en) begin
      if (q_ins.size() == 0)
        chk("dp_unexpected", 1, 0);
      else
        chk("dp_ins", dp_ins, q_ins.pop_front());
    end
  endtask

  task automatic rst_pulse();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q_id.delete();
    q_vrt.delete();
    q_ins.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    while (q_id.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    chk("drain_left", q_id.size(), 0);
    chk("drain_ins", q_ins.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int acc;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_vra = '0; req0_vrb = '0; req0_ins = '0;
    req1_vra = '0; req1_vrb = '0; req1_ins = '0;
    rsp_ready = 1'b1;
    inj = 1'b0;
    #12;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_dp_en", dp_en, 0);
    chk("rst_dp_vra", dp_vra, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single op from req0
    req0_valid = 1'b1;
    req0_vra = {16{8'h01}};
    req0_vrb = {16{8'h01}};
    req0_ins = 8'h00;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    cycle();
    req0_valid = 1'b0;
    chk("t1_dp_en", dp_en, 1);
    chk("t1_dp_vra", dp_vra, {16{8'h01}});
    chk("t1_dp_vrb", dp_vrb, {16{8'h01}});
    cycle();
    chk("t1_dp_en_off", dp_en, 0);
    chk("t1_dp_hold", dp_vra, {16{8'h01}});
    chk("t1_rsp_early", rsp_valid, 0);
    chk("t1_busy", busy, 1);
    cycle();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_vrt", rsp_vrt, {16{8'h02}});
    cycle();
    chk("t1_rsp_gone", rsp_valid, 0);
    chk("t1_idle", busy, 0);

    // Both requesters streaming
    rst_pulse();
    req0_vra = {16{8'h10}}; req0_vrb = {16{8'h03}}; req0_ins = 8'h11;
    req1_vra = {16{8'h21}}; req1_vrb = {16{8'h05}}; req1_ins = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_g0", req0_ready, (i % 2) == 0);
      chk("t2_g1", req1_ready, (i % 2) == 1);
      cycle();
    end
    drain();

    // Credit exhaustion with the consumer stalled
    rst_pulse();
    req0_vra = {16{8'h07}}; req0_vrb = {16{8'h30}}; req0_ins = 8'h33;
    req0_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req0_ready)
        acc++;
      cycle();
    end
    chk("t3_accepts", acc, 4);
    #1;
    chk("t3_ready_low", req0_ready, 0);
    chk("t3_busy", busy, 1);
    rsp_ready = 1'b1;
    #1;
    chk("t3_pop_ready", req0_ready, 1);
    cycle();
    rsp_ready = 1'b0;
    #1;
    chk("t3_ready_again", req0_ready, 0);

    // Full credits, both valid, pop frees exactly one grant
    req1_vra = {16{8'h40}}; req1_vrb = {16{8'h02}}; req1_ins = 8'h44;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    #1;
    chk("t4_g1", req1_ready, 1);
    chk("t4_g0", req0_ready, 0);
    cycle();
    rsp_ready = 1'b0;
    #1;
    chk("t4_full0", req0_ready, 0);
    chk("t4_full1", req1_ready, 0);
    cycle();
    rsp_ready = 1'b1;
    #1;
    chk("t4_flip0", req0_ready, 1);
    chk("t4_flip1", req1_ready, 0);
    cycle();
    drain();

    // Reset with ops in the tag pipe and the FIFO
    rst_pulse();
    req0_vra = {16{8'h05}}; req0_vrb = {16{8'h05}}; req0_ins = 8'h55;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++)
      cycle();
    chk("t5_pre_fifo", rsp_valid, 1);
    chk("t5_pre_dp", dp_en, 1);
    rst = 1'b0;
    #1;
    chk("t5_ready0", req0_ready, 0);
    chk("t5_dp_en", dp_en, 0);
    chk("t5_dp_vra", dp_vra, 0);
    chk("t5_dp_ins", dp_ins, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_vrt", rsp_vrt, 0);
    chk("t5_busy", busy, 0);
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    q_id.delete();
    q_vrt.delete();
    q_ins.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t5_no_rsp", rsp_valid, 0);
      chk("t5_no_busy", busy, 0);
    end
    chk("t5_no_err", err, 0);

    // Stray result with nothing issued
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    chk("t6_err", err, 1);
    chk("t6_empty", rsp_valid, 0);
    cycle();
    cycle();
    chk("t6_err_sticky", err, 1);
    chk("t6_still_empty", rsp_valid, 0);
    chk("t6_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
